keypad_entry_ctrl: RTL and testbench

Sequencer between the 4x4 keypad scanner and the countdown core. It synchronizes and debounces the scanner's `keydown`/`key` outputs and turns each accepted press into exactly one command. It accumulates digit keys into a 4-digit BCD MM:SS setpoint and issues load, start/pause, abort and error strobes to the countdown and display logic.

---
 rtl/keypad_entry_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Sits between the keypad scanner and the countdown core. It synchronizes and
// debounces keydown/key and turns each accepted press into one command. Digit
// keys build a 4-digit BCD MM:SS setpoint. CLEAR, BACKSPACE, ENTER and START
// become load, start/pause, abort and error strobes.
module keypad_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        keydown,
    input  logic [3:0]  key,
    input  logic        counting,
    output logic [15:0] entry,
    output logic [2:0]  digit_count,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        load_pulse,
    output logic [15:0] load_value,
    output logic        start_pulse,
    output logic        abort_pulse,
    output logic        error_pulse
);

    localparam logic [7:0] DB_LEN = DEBOUNCE_CYCLES[7:0];

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_BKSP  = 4'd11;
    localparam logic [3:0] KEY_ENTER = 4'd12;
    localparam logic [3:0] KEY_START = 4'd13;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        DISPATCH,
        HELD,
        DB_RELEASE
    } state_t;

    // Bit 0 is keydown and bits 4:1 are the key code. Every bit gets its own
    // two-flop synchronizer. The code is only used once keydown has been
    // stable for the whole debounce window, so bit skew between the code
    // lines does not matter.
    logic [4:0] raw_in;
    logic [4:0] sync_reg;

    assign raw_in = {key, keydown};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sync
            logic meta_bit_reg;
            logic sync_bit_reg;

            // Two-flop synchronizer for one raw scanner line
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_bit_reg <= 1'b0;
                    sync_bit_reg <= 1'b0;
                end else begin
                    meta_bit_reg <= raw_in[gi];
                    sync_bit_reg <= meta_bit_reg;
                end
            end

            assign sync_reg[gi] = sync_bit_reg;
        end
    endgenerate

    logic       kd_sync;
    logic [3:0] key_sync;

    assign kd_sync  = sync_reg[0];
    assign key_sync = sync_reg[4:1];

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [3:0]  key_cap_reg;
    logic [15:0] entry_reg;
    logic [2:0]  count_reg;
    logic [15:0] load_value_reg;
    logic [3:0]  key_code_reg;
    logic        key_valid_reg;
    logic        load_reg;
    logic        start_reg;
    logic        abort_reg;
    logic        error_reg;

    logic [15:0] entry_next;
    logic [2:0]  count_next;
    logic [15:0] load_value_next;
    logic        load_next;
    logic        start_next;
    logic        abort_next;
    logic        error_next;

    logic is_digit;
    logic sec_tens_bad;

    assign is_digit     = (key_cap_reg <= 4'd9);
    assign sec_tens_bad = (entry_reg[7:4] > 4'd5);

    // Decode the captured key into its effect on the setpoint and strobes.
    // The result is only committed in the DISPATCH cycle.
    always_comb begin
        entry_next      = entry_reg;
        count_next      = count_reg;
        load_value_next = load_value_reg;
        load_next       = 1'b0;
        start_next      = 1'b0;
        abort_next      = 1'b0;
        error_next      = 1'b0;

        if (!counting) begin
            if (is_digit) begin
                if (count_reg < 3'd4) begin
                    entry_next = {entry_reg[11:0], key_cap_reg};
                    count_next = count_reg + 3'd1;
                end else begin
                    error_next = 1'b1;
                end
            end else begin
                case (key_cap_reg)
                    KEY_CLEAR: begin
                        entry_next = 16'd0;
                        count_next = 3'd0;
                    end
                    KEY_BKSP: begin
                        if (count_reg != 3'd0) begin
                            entry_next = {4'd0, entry_reg[15:4]};
                            count_next = count_reg - 3'd1;
                        end
                    end
                    KEY_ENTER: begin
                        if (count_reg == 3'd0 || sec_tens_bad) begin
                            error_next = 1'b1;
                        end else begin
                            load_value_next = entry_reg;
                            load_next       = 1'b1;
                            entry_next      = 16'd0;
                            count_next      = 3'd0;
                        end
                    end
                    KEY_START: start_next = 1'b1;
                    default: ;
                endcase
            end
        end else begin
            // While a countdown is in progress only START and CLEAR are
            // meaningful. Editing keys are rejected.
            if (is_digit || key_cap_reg == KEY_BKSP || key_cap_reg == KEY_ENTER) begin
                error_next = 1'b1;
            end else if (key_cap_reg == KEY_START) begin
                start_next = 1'b1;
            end else if (key_cap_reg == KEY_CLEAR) begin
                abort_next = 1'b1;
                entry_next = 16'd0;
                count_next = 3'd0;
            end
        end
    end

    // Debounce/dispatch sequencer. It also holds every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            key_cap_reg    <= 4'd0;
            entry_reg      <= 16'd0;
            count_reg      <= 3'd0;
            load_value_reg <= 16'd0;
            key_code_reg   <= 4'd0;
            key_valid_reg  <= 1'b0;
            load_reg       <= 1'b0;
            start_reg      <= 1'b0;
            abort_reg      <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            key_valid_reg <= 1'b0;
            load_reg      <= 1'b0;
            start_reg     <= 1'b0;
            abort_reg     <= 1'b0;
            error_reg     <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (kd_sync) begin
                        state_reg <= DB_PRESS;
                        cnt_reg   <= 8'd1;
                    end
                end
                DB_PRESS: begin
                    if (!kd_sync) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == DB_LEN) begin
                        key_cap_reg <= key_sync;
                        state_reg   <= DISPATCH;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DISPATCH: begin
                    key_valid_reg  <= 1'b1;
                    key_code_reg   <= key_cap_reg;
                    entry_reg      <= entry_next;
                    count_reg      <= count_next;
                    load_value_reg <= load_value_next;
                    load_reg       <= load_next;
                    start_reg      <= start_next;
                    abort_reg      <= abort_next;
                    error_reg      <= error_next;
                    state_reg      <= HELD;
                end
                HELD: begin
                    if (!kd_sync) begin
                        state_reg <= DB_RELEASE;
                        cnt_reg   <= 8'd1;
                    end
                end
                DB_RELEASE: begin
                    if (kd_sync) begin
                        state_reg <= HELD;
                    end else if (cnt_reg == DB_LEN) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign entry       = entry_reg;
    assign digit_count = count_reg;
    assign key_valid   = key_valid_reg;
    assign key_code    = key_code_reg;
    assign load_pulse  = load_reg;
    assign load_value  = load_value_reg;
    assign start_pulse = start_reg;
    assign abort_pulse = abort_reg;
    assign error_pulse = error_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl. A behavioural reference model runs on raw
// input samples: it measures run lengths of keydown and keeps the entry as a
// list of digits. A compare process checks the model every cycle. Directed
// sequences pin the model with literal values, and random presses follow.
module tb_keypad_entry_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        keydown = 1'b0;
    logic [3:0]  key = 4'd0;
    logic        counting = 1'b0;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        load_pulse;
    logic [15:0] load_value;
    logic        start_pulse;
    logic        abort_pulse;
    logic        error_pulse;

    keypad_entry_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .keydown(keydown),
        .key(key),
        .counting(counting),
        .entry(entry),
        .digit_count(digit_count),
        .key_valid(key_valid),
        .key_code(key_code),
        .load_pulse(load_pulse),
        .load_value(load_value),
        .start_pulse(start_pulse),
        .abort_pulse(abort_pulse),
        .error_pulse(error_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int e_cyc = 0;
    int kv_cyc = -1;
    int n_kv = 0, n_load = 0, n_start = 0, n_abort = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_armed = 1'b1;
    int          m_run = 0;
    bit          m_skip = 1'b0;
    bit          p_valid = 1'b0;
    int          p_due = 0;
    logic [3:0]  p_key = 4'd0;
    int          m_edge = 0;
    int          digits[$];
    logic [15:0] m_load_value = 16'd0;
    logic [3:0]  m_key_code = 4'd0;
    bit          m_kv = 0, m_load = 0, m_start = 0, m_abort = 0, m_err = 0;

    function automatic logic [15:0] digits_value();
        logic [15:0] v;
        v = 16'd0;
        foreach (digits[i]) v = v * 16 + 16'(digits[i]);
        return v;
    endfunction

    task automatic apply(input logic [3:0] k, input logic c);
        int sec_tens;
        m_kv = 1;
        m_key_code = k;
        sec_tens = (digits.size() >= 2) ? digits[digits.size() - 2] : 0;
        if (!c) begin
            if (k <= 9) begin
                if (digits.size() < 4) digits.push_back(int'(k));
                else m_err = 1;
            end else if (k == 10) begin
                digits.delete();
            end else if (k == 11) begin
                if (digits.size() > 0) void'(digits.pop_back());
            end else if (k == 12) begin
                if (digits.size() == 0 || sec_tens > 5) m_err = 1;
                else begin
                    m_load_value = digits_value();
                    m_load = 1;
                    digits.delete();
                end
            end else if (k == 13) begin
                m_start = 1;
            end
        end else begin
            if (k == 13) m_start = 1;
            else if (k == 10) begin
                m_abort = 1;
                digits.delete();
            end else if (k <= 12) m_err = 1;
        end
    endtask

    // A press is accepted after D+1 consecutive raw-high samples. The
    // sample taken during the dispatch cycle is ignored. A release needs
    // D+1 consecutive raw-low samples. Results appear 3 edges after the
    // accepting sample.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_armed = 1; m_run = 0; m_skip = 0; p_valid = 0; m_edge = 0;
            digits.delete();
            m_load_value = 16'd0; m_key_code = 4'd0;
            m_kv = 0; m_load = 0; m_start = 0; m_abort = 0; m_err = 0;
        end else begin
            m_edge++;
            m_kv = 0; m_load = 0; m_start = 0; m_abort = 0; m_err = 0;
            if (p_valid && m_edge == p_due) begin
                p_valid = 0;
                apply(p_key, counting);
            end
            if (m_skip) begin
                m_skip = 0;
            end else if (m_armed) begin
                m_run = keydown ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    p_valid = 1; p_due = m_edge + 3; p_key = key;
                    m_armed = 0; m_run = 0; m_skip = 1;
                end
            end else begin
                m_run = !keydown ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    m_armed = 1; m_run = 0;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("entry", entry, digits_value());
            chk("digit_count", {13'd0, digit_count}, 16'(digits.size()));
            chk("key_valid", {15'd0, key_valid}, {15'd0, m_kv});
            chk("key_code", {12'd0, key_code}, {12'd0, m_key_code});
            chk("load_value", load_value, m_load_value);
            chk("pulses", {12'd0, load_pulse, start_pulse, abort_pulse, error_pulse},
                {12'd0, m_load, m_start, m_abort, m_err});
            chk("one_strobe", 16'($countones({load_pulse, start_pulse, abort_pulse, error_pulse}) <= 1), 16'd1);
            if (key_valid) begin n_kv++; kv_cyc = cyc; end
            if (load_pulse) n_load++;
            if (start_pulse) n_start++;
            if (abort_pulse) n_abort++;
            if (error_pulse) n_err++;
        end
    end

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        @(negedge clk);
        key = code;
        keydown = 1'b1;
        e_cyc = cyc + 1;
        repeat (hold) @(negedge clk);
        keydown = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    int c0;

    initial begin
        // Reset state
        #12;
        chk("rst_entry", entry, 16'd0);
        chk("rst_strobes", {7'd0, key_valid, load_pulse, start_pulse, abort_pulse, error_pulse, digit_count, 1'b0},
            16'd0);
        chk("rst_load_value", load_value, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1,3,4,5 then ENTER
        press(4'd1, 10, 10);
        chk("lat_press", 16'(kv_cyc - e_cyc), 16'(D + 3));
        chk("lit_e1", entry, 16'h0001);
        press(4'd3, 10, 10);
        chk("lit_e13", entry, 16'h0013);
        press(4'd4, 10, 10);
        chk("lit_e134", entry, 16'h0134);
        press(4'd5, 10, 10);
        chk("lit_e1345", entry, 16'h1345);
        chk("lit_model_1345", digits_value(), 16'h1345);
        c0 = n_load;
        press(4'd12, 10, 10);
        chk("lit_load_cnt", 16'(n_load - c0), 16'd1);
        chk("lit_load_value", load_value, 16'h1345);
        chk("lit_model_load", m_load_value, 16'h1345);
        chk("lit_clr_after_load", {entry[12:0], digit_count}, 16'd0);

        // 0,7,6 then ENTER: seconds tens of 7 is rejected
        press(4'd0, 10, 10);
        press(4'd7, 10, 10);
        press(4'd6, 10, 10);
        c0 = n_err;
        press(4'd12, 10, 10);
        chk("lit_sec_err", 16'(n_err - c0), 16'd1);
        chk("lit_keep_076", entry, 16'h0076);
        chk("lit_no_load", 16'(n_load), 16'd1);
        press(4'd10, 10, 10);

        // Five digits, BACKSPACE twice, CLEAR
        for (int d = 1; d <= 4; d++) press(4'(d), 10, 10);
        c0 = n_err;
        press(4'd5, 10, 10);
        chk("lit_fifth_err", 16'(n_err - c0), 16'd1);
        chk("lit_e1234", entry, 16'h1234);
        press(4'd11, 10, 10);
        press(4'd11, 10, 10);
        chk("lit_bs_entry", entry, 16'h0012);
        chk("lit_bs_count", {13'd0, digit_count}, 16'd2);
        press(4'd10, 10, 10);
        chk("lit_clear", entry, 16'd0);
        c0 = n_err;
        press(4'd11, 10, 10);
        chk("lit_bs_empty_noerr", 16'(n_err - c0), 16'd0);

        // Short glitch, then a press with a one-cycle dropout while held
        c0 = n_kv;
        @(negedge clk); key = 4'd9; keydown = 1'b1;
        repeat (3) @(negedge clk); keydown = 1'b0;
        repeat (10) @(negedge clk);
        chk("lit_glitch", 16'(n_kv - c0), 16'd0);
        @(negedge clk); key = 4'd2; keydown = 1'b1;
        repeat (10) @(negedge clk); keydown = 1'b0;
        @(negedge clk); keydown = 1'b1;
        repeat (10) @(negedge clk); keydown = 1'b0;
        repeat (12) @(negedge clk);
        chk("lit_dropout", 16'(n_kv - c0), 16'd1);
        chk("lit_e2", entry, 16'h0002);

        // Countdown running
        counting = 1'b1;
        c0 = n_start;
        press(4'd13, 10, 10);
        chk("lit_cnt_start", 16'(n_start - c0), 16'd1);
        c0 = n_err;
        press(4'd5, 10, 10);
        chk("lit_cnt_digit_err", 16'(n_err - c0), 16'd1);
        chk("lit_cnt_keep", entry, 16'h0002);
        c0 = n_abort;
        press(4'd10, 10, 10);
        chk("lit_cnt_abort", 16'(n_abort - c0), 16'd1);
        chk("lit_cnt_abort_entry", entry, 16'd0);
        counting = 1'b0;

        // Asynchronous reset during DB_PRESS with the key still held
        press(4'd3, 10, 10);
        @(negedge clk); key = 4'd7; keydown = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_entry", entry, 16'd0);
        chk("arst_load_value", load_value, 16'd0);
        chk("arst_misc", {8'd0, key_code, 1'b0, digit_count}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e_cyc = cyc + 1;
        c0 = n_kv;
        repeat (20) @(negedge clk);
        keydown = 1'b0;
        repeat (12) @(negedge clk);
        chk("arst_one_kv", 16'(n_kv - c0), 16'd1);
        chk("arst_latency", 16'(kv_cyc - e_cyc), 16'(D + 3));
        chk("arst_e7", entry, 16'h0007);

        // Random presses: random codes, hold/gap lengths and counting
        for (int i = 0; i < 300; i++) begin
            counting = ($urandom_range(0, 3) == 0);
            press(4'($urandom_range(0, 15)), $urandom_range(1, 12), $urandom_range(1, 12));
        end
        counting = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
